// File: rtl/arbiter_wrr_burst.sv
// Weighted round-robin arbiter with packet-granular grants.
// One owner holds a registered one-hot grant for whole multi-beat packets,
// and keeps it for up to its programmed weight in packets. Every hand-over
// passes through one idle re-arbitration cycle, and priority then rotates
// to the requester after the releasing owner.
module arbiter_wrr_burst #(
   parameter int REQ_NUM  = 4,
   parameter int WEIGHT_W = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [REQ_NUM-1:0]            req,
   input  logic [REQ_NUM-1:0]            last,
   input  logic [REQ_NUM*WEIGHT_W-1:0]   weight,
   input  logic [REQ_NUM-1:0]            base,
   input  logic                          ready,
   output logic [REQ_NUM-1:0]            gnt,
   output logic                          gnt_vld,
   output logic                          xfer,
   output logic                          busy
);

   localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Index of the lowest set bit, or 0 when no bit is set.
   function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [REQ_NUM-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
         r = v[j] ? IDX_W'(j) : r;
      end
      return r;
   endfunction

   // One-hot vector with only bit idx set.
   function automatic logic [REQ_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [REQ_NUM-1:0] v;
      v = '0;
      for (int j = 0; j < REQ_NUM; j++) begin
         v[j] = (IDX_W'(j) == idx) ? 1'b1 : 1'b0;
      end
      return v;
   endfunction

   state_t                state_r;
   logic [REQ_NUM-1:0]    gnt_r;
   logic                  busy_r;
   logic [WEIGHT_W-1:0]   credit_r;
   logic [IDX_W-1:0]      owner_r;
   logic [IDX_W-1:0]      ptr_r;

   logic [IDX_W-1:0]      win_idx_s;
   logic [WEIGHT_W-1:0]   win_weight_s;
   logic [WEIGHT_W-1:0]   load_credit_s;
   logic [IDX_W-1:0]      next_ptr_s;
   logic                  gnt_vld_s;
   logic                  xfer_s;
   logic                  beat_last_s;
   logic                  release_s;

   // Winner search from ptr upward with wrap: a set request at or above ptr
   // beats any request below it; within each region the lowest index wins.
   always_comb begin
      win_idx_s = ptr_r;
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
         win_idx_s = (req[j] && (IDX_W'(j) < ptr_r)) ? IDX_W'(j) : win_idx_s;
      end
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
         win_idx_s = (req[j] && (IDX_W'(j) >= ptr_r)) ? IDX_W'(j) : win_idx_s;
      end
   end

   // Winner's weight field; a zero weight still grants one packet.
   always_comb begin
      win_weight_s = '0;
      for (int j = 0; j < REQ_NUM; j++) begin
         win_weight_s = (IDX_W'(j) == win_idx_s) ? weight[j*WEIGHT_W +: WEIGHT_W] : win_weight_s;
      end
      if (win_weight_s == '0) begin
         load_credit_s = WEIGHT_W'(1'b1);
      end else begin
         load_credit_s = win_weight_s;
      end
   end

   // Pointer value after release: the requester following the owner.
   always_comb begin
      if (owner_r == IDX_W'(REQ_NUM - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = owner_r + IDX_W'(1'b1);
      end
   end

   // Beat acceptance and release decision for the current owner.
   always_comb begin
      gnt_vld_s   = |gnt_r;
      xfer_s      = gnt_vld_s & req[owner_r] & ready;
      beat_last_s = xfer_s & last[owner_r];
      if (state_r == ST_GRANT) begin
         release_s = (beat_last_s && (credit_r == WEIGHT_W'(1'b1))) ||
                     (!busy_r && !req[owner_r]);
      end else begin
         release_s = 1'b0;
      end
   end

   // Arbitration FSM: grant, packet/credit tracking and pointer rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         gnt_r    <= '0;
         busy_r   <= 1'b0;
         credit_r <= '0;
         owner_r  <= '0;
         ptr_r    <= lowest_set_idx(base);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|req) begin
                  state_r  <= ST_GRANT;
                  gnt_r    <= onehot(win_idx_s);
                  owner_r  <= win_idx_s;
                  credit_r <= load_credit_s;
                  busy_r   <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (release_s) begin
                  state_r  <= ST_IDLE;
                  gnt_r    <= '0;
                  busy_r   <= 1'b0;
                  credit_r <= '0;
                  ptr_r    <= next_ptr_s;
               end else if (beat_last_s) begin
                  busy_r   <= 1'b0;
                  credit_r <= credit_r - WEIGHT_W'(1'b1);
               end else if (xfer_s) begin
                  busy_r   <= 1'b1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               gnt_r    <= '0;
               busy_r   <= 1'b0;
               credit_r <= '0;
            end
         endcase
      end
   end

   assign gnt     = gnt_r;
   assign gnt_vld = gnt_vld_s;
   assign xfer    = xfer_s;
   assign busy    = busy_r;

endmodule

// File: doc/arbiter_wrr_burst.md
Name: arbiter_wrr_burst

Overview:
Weighted round-robin arbiter that shares one downstream resource between REQ_NUM requesters at packet granularity. The grant is registered and held for a whole multi-beat packet. An owner may keep the grant for up to its programmed weight in packets before priority rotates. It sits in front of shared buses and memory ports where the combinational per-cycle round-robin arbiter would split packets.

Parameters:
REQ_NUM, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-requester weight field

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  REQ_NUM  per-requester beat valid / request
last  input  REQ_NUM  per-requester final-beat marker, qualified by req
weight  input  REQ_NUM*WEIGHT_W  packets allowed per tenure; field i = bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static
base  input  REQ_NUM  one-hot initial highest priority, sampled only during reset
ready  input  1  shared resource accepts a beat this cycle
gnt  output  REQ_NUM  registered one-hot grant, owner index
gnt_vld  output  1  |gnt
xfer  output  1  beat accepted: gnt_vld & req[owner] & ready
busy  output  1  owner is mid-packet (first beat accepted, last not yet accepted)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: gnt=0, gnt_vld=0, xfer=0, busy=0, state=IDLE, credit=0. The priority pointer ptr loads from base. If base is 0 or not one-hot, ptr = lowest set bit of base, or index 0 if base=0.
- The pointer has highest priority. Search order is ptr, ptr+1, ..., REQ_NUM-1, 0, ..., ptr-1.
- State IDLE:
  - gnt=0.
  - If |req, the winner is the first set req in search order.
  - Next cycle: gnt = onehot(winner), state=GRANT, credit = weight[winner], with weight 0 loaded as 1.
  - Latency from request to grant is 1 cycle.
- State GRANT, owner o:
  - Beat accepted when req[o] & ready (xfer=1).
  - First accepted beat without last sets busy=1.
  - Accepted beat with last[o] clears busy and decrements credit.
  - A single-beat packet (req & last & ready with busy=0) counts as one packet.
- Release from GRANT to IDLE. On release gnt=0 the next cycle and ptr = (o+1) mod REQ_NUM.
  - (a) The last beat is accepted with credit==1.
  - (b) busy==0 and req[o]==0, meaning the owner is idle between packets; unused credit is discarded.
- No release while busy. If req[o] drops mid-packet, the grant is held until the last beat is accepted.
- There is always one idle re-arbitration cycle (gnt=0) between owners.
- ready is ignored in IDLE. Requests and last from non-owners are ignored in GRANT.
- Weight is sampled only on the IDLE->GRANT transition. Later changes do not affect the current tenure.
- ptr changes only on release, so an owner cannot re-win ahead of waiting requesters.
- credit counter is WEIGHT_W bits; maximum tenure is 2^WEIGHT_W-1 packets.
- Reset asserted mid-packet returns all state to reset values immediately (asynchronous); the packet is abandoned.

Test Plan:
- Reset with base=4'b0100, req=4'b1011 held, weights all 1, single-beat packets, ready=1 -> grants in order 3, 0, 1, 3, 0 with one gnt=0 cycle between each; no grant to index 2.
- REQ_NUM=4, req[1] only, weight[1]=3, 2-beat packets back-to-back, ready=1 -> gnt=0010 held for 6 xfers, release after 3rd last, then re-granted to 1 after one idle cycle.
- Owner 0 in 4-beat packet, ready toggles 1,0,1,0,..., req[2] asserted mid-packet -> gnt stays 0001 until 4th beat accepted, busy=1 throughout, then gnt=0100.
- Owner 2 drops req after first of 3 allowed packets (weight=3) -> release next cycle, ptr=3, unused credit discarded, req[3] granted next.
- weight[0]=0 and weight[0]=15 -> exactly 1 and exactly 15 packets per tenure respectively.
- Assert rst_n=0 mid-packet with gnt=0010, busy=1 -> gnt=0, busy=0, xfer=0 immediately; after deassert with base=0001 and req=0011, grant goes to 0 first.
